// File: rtl/traffic_pkg.sv
// Shared definitions for the junction controller: phase codes and lamp patterns.
// Lamp patterns are {R,A,G} for one direction.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED   = 3'd0,
    PH_RED_AMBER = 3'd1,
    PH_GREEN     = 3'd2,
    PH_AMBER     = 3'd3,
    PH_WALK      = 3'd4
  } phase_e;

  localparam logic [2:0] RAG_RED       = 3'b100;
  localparam logic [2:0] RAG_RED_AMBER = 3'b110;
  localparam logic [2:0] RAG_GREEN     = 3'b001;
  localparam logic [2:0] RAG_AMBER     = 3'b010;

endpackage

// File: rtl/traffic_rr_next_sel.sv
// Combinational round-robin pick: starting one above the current index and
// wrapping, return the first direction with a request. The current direction
// itself is never a candidate.
module rr_next_sel #(
  parameter int NUM_DIR = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [IDX_W-1:0]   cur,
  output logic               valid,
  output logic [IDX_W-1:0]   nxt
);

  int idx;

  // Scan farthest offset first so the nearest requester overwrites earlier hits.
  always_comb begin
    valid = 1'b0;
    nxt   = cur;
    idx   = 0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_DIR;
      if (req[idx[IDX_W-1:0]]) begin
        valid = 1'b1;
        nxt   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// N-direction junction controller: one green at a time, round-robin over
// vehicle requests, UK lamp sequence and all-red clearance between grants.
// Optional pedestrian walk phase after amber when TRAFFIC_PED_EN is defined.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 8,
  parameter int AMBER_CYC  = 2,
  parameter int RA_CYC     = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 6,
  localparam int IDX_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DIR-1:0]     car_req,
`ifdef TRAFFIC_PED_EN
  input  logic                   ped_req,
  output logic                   walk,
`endif
  output logic [3*NUM_DIR-1:0]   rag,
  output logic [IDX_W-1:0]       active_dir,
  output logic [2:0]             phase
);

  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] RA_LD     = CNT_W'(RA_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] AMBER_LD  = CNT_W'(AMBER_CYC - 1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] act_q, act_d;
  logic [IDX_W-1:0] nxt_q, nxt_d;
  logic             rr_vld;
  logic [IDX_W-1:0] rr_nxt;
  logic             cnt_zero;

`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_CYC - 1);
  logic ped_pend_q, ped_pend_d, ped_clr;
`else
  // The walk dwell only matters when the pedestrian phase is built in.
  logic unused_walk_cyc;
  assign unused_walk_cyc = ^WALK_CYC;
`endif

  rr_next_sel #(
    .NUM_DIR(NUM_DIR),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req  (car_req),
    .cur  (act_q),
    .valid(rr_vld),
    .nxt  (rr_nxt)
  );

  assign cnt_zero = (cnt_q == '0);

  // Phase sequencing, dwell counter and direction hand-over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    nxt_d   = nxt_q;
`ifdef TRAFFIC_PED_EN
    ped_clr = 1'b0;
`endif
    case (state_q)
      PH_ALL_RED: begin
        if (cnt_zero) begin
          state_d = PH_RED_AMBER;
          cnt_d   = RA_LD;
          act_d   = nxt_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH_RED_AMBER: begin
        if (cnt_zero) begin
          state_d = PH_GREEN;
          cnt_d   = GREEN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH_GREEN: begin
        // Once minimum green has elapsed, hold at zero until another direction asks.
        if (cnt_zero) begin
          if (rr_vld) begin
            state_d = PH_AMBER;
            cnt_d   = AMBER_LD;
            nxt_d   = rr_nxt;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH_AMBER: begin
        if (cnt_zero) begin
`ifdef TRAFFIC_PED_EN
          if (ped_pend_q) begin
            state_d = PH_WALK;
            cnt_d   = WALK_LD;
            ped_clr = 1'b1;
          end else begin
            state_d = PH_ALL_RED;
            cnt_d   = ALLRED_LD;
          end
`else
          state_d = PH_ALL_RED;
          cnt_d   = ALLRED_LD;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef TRAFFIC_PED_EN
      PH_WALK: begin
        if (cnt_zero) begin
          state_d = PH_ALL_RED;
          cnt_d   = ALLRED_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = PH_ALL_RED;
        cnt_d   = ALLRED_LD;
      end
    endcase
  end

`ifdef TRAFFIC_PED_EN
  // A new request in the same cycle as the clear wins, so it is served next round.
  always_comb begin
    ped_pend_d = (ped_pend_q & ~ped_clr) | ped_req;
  end
`endif

  // Control registers with synchronous reset to all-red.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_ALL_RED;
      cnt_q   <= ALLRED_LD;
      act_q   <= '0;
      nxt_q   <= '0;
`ifdef TRAFFIC_PED_EN
      ped_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      nxt_q   <= nxt_d;
`ifdef TRAFFIC_PED_EN
      ped_pend_q <= ped_pend_d;
`endif
    end
  end

  // Lamp decode: only the active direction ever leaves red.
  always_comb begin
    rag = {NUM_DIR{RAG_RED}};
    for (int i = 0; i < NUM_DIR; i++) begin
      if (i == int'(act_q)) begin
        case (state_q)
          PH_RED_AMBER: rag[3*i +: 3] = RAG_RED_AMBER;
          PH_GREEN:     rag[3*i +: 3] = RAG_GREEN;
          PH_AMBER:     rag[3*i +: 3] = RAG_AMBER;
          default:      rag[3*i +: 3] = RAG_RED;
        endcase
      end
    end
  end

  assign active_dir = act_q;
  assign phase      = state_q;
`ifdef TRAFFIC_PED_EN
  assign walk       = (state_q == PH_WALK);
`endif

endmodule
